ddr_axi_read: RTL and testbench

AXI4 read-burst master for the DDR path: accepts a burst request (start address, beat count) from the user-interface side, issues one INCR burst on the AXI4 read-address channel, and streams returned beats into the UI read FIFO with FIFO-full backpressure. It is the read-direction counterpart of the DDR AXI write master and sits between the UI read FIFO and the memory controller's AXI4 slave port.

---
 rtl/ddr_axi_pkg.sv | 18 +
 rtl/ddr_axi_rd_beat_ctr.sv | 35 +++
 rtl/ddr_axi_read.sv | 163 ++++++++++++++++
 tb/tb_ddr_axi_read.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_axi_pkg.sv
// Shared AXI4 constants and read-master state encoding for the DDR AXI path.
package ddr_axi_pkg;

    typedef enum logic [2:0] {
        RD_IDLE  = 3'd0,
        RA_START = 3'd1,
        RA_WAIT  = 3'd2,
        RD_PROC  = 3'd3,
        RD_DONE  = 3'd4
    } rd_state_e;

    localparam logic [3:0] AXI_ID_DDR     = 4'b1111;
    localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [3:0] AXI_CACHE_DDR  = 4'b0011;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/ddr_axi_rd_beat_ctr.sv
// Remaining-beat counter: load on request, decrement per beat, saturate at zero.
module ddr_axi_rd_beat_ctr #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/ddr_axi_read.sv
// AXI4 read-burst master feeding the UI read FIFO.
// Optional response checking enabled by defining DDR_AXI_READ_CHECK_EN.
module ddr_axi_read
    import ddr_axi_pkg::*;
#(
    parameter int DATA_WIDTH      = 64,
    parameter int ADDR_WIDTH      = 29,
    parameter int BURST_LEN_WIDTH = 8
) (
    input  logic                       ACLK,
    input  logic                       ARESETN,
    input  logic                       rd_start,
    input  logic [BURST_LEN_WIDTH-1:0] rd_burst_len,
    input  logic [ADDR_WIDTH-1:0]      rd_start_addr,
    output logic                       rd_ready,
    output logic [DATA_WIDTH-1:0]      rd_fifo_wr_data,
    output logic                       rd_fifo_wr_valid,
    input  logic                       rd_fifo_full,
    output logic                       rd_done,
    output logic                       rd_err,
    output logic [3:0]                 m_axi_arid,
    output logic [ADDR_WIDTH-1:0]      m_axi_araddr,
    output logic [BURST_LEN_WIDTH-1:0] m_axi_arlen,
    output logic [2:0]                 m_axi_arsize,
    output logic [1:0]                 m_axi_arburst,
    output logic                       m_axi_arlock,
    output logic [3:0]                 m_axi_arcache,
    output logic [2:0]                 m_axi_arprot,
    output logic [3:0]                 m_axi_arqos,
    output logic                       m_axi_arvalid,
    input  logic                       m_axi_arready,
    input  logic [3:0]                 m_axi_rid,
    input  logic [DATA_WIDTH-1:0]      m_axi_rdata,
    input  logic [1:0]                 m_axi_rresp,
    input  logic                       m_axi_rlast,
    input  logic                       m_axi_rvalid,
    output logic                       m_axi_rready
);

    rd_state_e                  state_q, state_d;
    logic                       arvalid_q, arvalid_d;
    logic [ADDR_WIDTH-1:0]      araddr_q;
    logic [BURST_LEN_WIDTH-1:0] arlen_q;
    logic                       accept;
    logic                       beat;
    logic                       cnt_zero;

    always_comb begin
        state_d   = state_q;
        arvalid_d = arvalid_q;
        accept    = 1'b0;
        case (state_q)
            RD_IDLE: begin
                if (rd_start && (rd_burst_len != '0)) begin
                    accept  = 1'b1;
                    state_d = RA_START;
                end
            end
            RA_START: begin
                arvalid_d = 1'b1;
                state_d   = RA_WAIT;
            end
            RA_WAIT: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = RD_PROC;
                end
            end
            RD_PROC: begin
                if (beat && m_axi_rlast) begin
                    state_d = RD_DONE;
                end
            end
            RD_DONE: begin
                state_d = RD_IDLE;
            end
            default: begin
                state_d   = RD_IDLE;
                arvalid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= RD_IDLE;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            arlen_q   <= '0;
        end else begin
            state_q   <= state_d;
            arvalid_q <= arvalid_d;
            if (accept) begin
                araddr_q <= rd_start_addr;
                arlen_q  <= rd_burst_len - 1'b1;
            end
        end
    end

    ddr_axi_rd_beat_ctr #(
        .WIDTH(BURST_LEN_WIDTH)
    ) u_beat_ctr (
        .clk_i      (ACLK),
        .rst_n_i    (ARESETN),
        .load_i     (accept),
        .load_val_i (rd_burst_len - 1'b1),
        .dec_i      (beat),
        .zero_o     (cnt_zero)
    );

    // Data is forwarded combinationally so a full FIFO simply stalls the slave.
    assign m_axi_rready     = (state_q == RD_PROC) && !rd_fifo_full;
    assign beat             = m_axi_rvalid && m_axi_rready;
    assign rd_fifo_wr_data  = m_axi_rdata;
    assign rd_fifo_wr_valid = beat;
    assign rd_ready         = (state_q == RD_IDLE);
    assign rd_done          = (state_q == RD_DONE);

    assign m_axi_arid    = AXI_ID_DDR;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arsize  = AXI_SIZE_8B;
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = AXI_CACHE_DDR;
    assign m_axi_arprot  = '0;
    assign m_axi_arqos   = '0;
    assign m_axi_arvalid = arvalid_q;

`ifdef DDR_AXI_READ_CHECK_EN
    logic err_q, err_d;
    logic beat_bad;

    assign beat_bad = beat && ((m_axi_rresp != AXI_RESP_OKAY) ||
                               (m_axi_rid != AXI_ID_DDR) ||
                               (m_axi_rlast && !cnt_zero) ||
                               (!m_axi_rlast && cnt_zero));

    always_comb begin
        err_d = err_q;
        if (accept) begin
            err_d = 1'b0;
        end else if (beat_bad) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign rd_err = err_q;
`else
    logic unused_chk;
    assign unused_chk = ^{cnt_zero, m_axi_rid, m_axi_rresp};
    assign rd_err     = 1'b0;
`endif

endmodule

// File: tb/tb_ddr_axi_read.sv
// Directed, table-driven bench for ddr_axi_read with hand-written reset/len-0 sequences.
module tb_ddr_axi_read;

    localparam int DW = 64;
    localparam int AW = 29;
    localparam int BW = 8;
`ifdef DDR_AXI_READ_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          ACLK = 1'b0;
    logic          ARESETN;
    logic          rd_start;
    logic [BW-1:0] rd_burst_len;
    logic [AW-1:0] rd_start_addr;
    logic          rd_ready;
    logic [DW-1:0] rd_fifo_wr_data;
    logic          rd_fifo_wr_valid;
    logic          rd_fifo_full;
    logic          rd_done;
    logic          rd_err;
    logic [3:0]    m_axi_arid;
    logic [AW-1:0] m_axi_araddr;
    logic [BW-1:0] m_axi_arlen;
    logic [2:0]    m_axi_arsize;
    logic [1:0]    m_axi_arburst;
    logic          m_axi_arlock;
    logic [3:0]    m_axi_arcache;
    logic [2:0]    m_axi_arprot;
    logic [3:0]    m_axi_arqos;
    logic          m_axi_arvalid;
    logic          m_axi_arready;
    logic [3:0]    m_axi_rid;
    logic [DW-1:0] m_axi_rdata;
    logic [1:0]    m_axi_rresp;
    logic          m_axi_rlast;
    logic          m_axi_rvalid;
    logic          m_axi_rready;

    int checks = 0;
    int errors = 0;

    always #5 ACLK = ~ACLK;

    ddr_axi_read #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .BURST_LEN_WIDTH(BW)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .rd_start(rd_start), .rd_burst_len(rd_burst_len), .rd_start_addr(rd_start_addr),
        .rd_ready(rd_ready), .rd_fifo_wr_data(rd_fifo_wr_data), .rd_fifo_wr_valid(rd_fifo_wr_valid),
        .rd_fifo_full(rd_fifo_full), .rd_done(rd_done), .rd_err(rd_err),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    typedef struct {
        int            len;
        logic [AW-1:0] addr;
        int            ar_delay;
        bit            full_toggle;
        int            err_beat;
        logic [BW-1:0] exp_arlen;
        bit            exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_burst(input vec_t v);
        int            i;
        int            c;
        logic          full;
        logic [DW-1:0] exp_data;

        rd_start      = 1'b1;
        rd_burst_len  = v.len[BW-1:0];
        rd_start_addr = v.addr;
        #1;
        chk("rd_ready_idle", 64'(rd_ready), 64'd1);
        tick();
        rd_start     = 1'b0;
        rd_burst_len = '0;
        chk("err_clr_on_accept", 64'(rd_err), 64'd0);
        chk("arvalid_ra_start", 64'(m_axi_arvalid), 64'd0);
        chk("rd_ready_busy", 64'(rd_ready), 64'd0);

        tick();
        chk("arvalid_set", 64'(m_axi_arvalid), 64'd1);
        chk("araddr", 64'(m_axi_araddr), 64'(v.addr));
        chk("arlen", 64'(m_axi_arlen), 64'(v.exp_arlen));
        chk("ar_consts", {44'd0, m_axi_arid, m_axi_arsize, m_axi_arburst, m_axi_arlock,
                          m_axi_arcache, m_axi_arprot, m_axi_arqos},
            {44'd0, 4'hF, 3'b011, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0});
        for (int d = 0; d < v.ar_delay; d++) begin
            tick();
            chk("arvalid_hold", 64'(m_axi_arvalid), 64'd1);
            chk("rready_before_proc", 64'(m_axi_rready), 64'd0);
        end
        m_axi_arready = 1'b1;
        tick();
        m_axi_arready = 1'b0;
        chk("arvalid_drop", 64'(m_axi_arvalid), 64'd0);

        i = 0;
        c = 0;
        while (i < v.len && c < 4 * v.len + 16) begin
            full          = v.full_toggle ? logic'(c % 2) : 1'b0;
            exp_data      = 64'hC0DE_0000_0000_0000 | (64'(v.addr) << 8) | 64'(i);
            rd_fifo_full  = full;
            m_axi_rvalid  = 1'b1;
            m_axi_rdata   = exp_data;
            m_axi_rid     = 4'hF;
            m_axi_rresp   = (i == v.err_beat) ? 2'b10 : 2'b00;
            m_axi_rlast   = (i == v.len - 1);
            #1;
            chk("rready", 64'(m_axi_rready), 64'(!full));
            chk("wr_valid", 64'(rd_fifo_wr_valid), 64'(!full));
            if (!full) chk("wr_data", rd_fifo_wr_data, exp_data);
            tick();
            if (!full) i++;
            c++;
        end
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        m_axi_rresp  = 2'b00;
        rd_fifo_full = 1'b0;
        chk("beat_count", 64'(i), 64'(v.len));
        #1;
        chk("rd_done_pulse", 64'(rd_done), 64'd1);
        chk("rd_ready_in_done", 64'(rd_ready), 64'd0);
        chk("rd_err_after", 64'(rd_err), 64'(v.exp_err));
        chk("wr_valid_idle", 64'(rd_fifo_wr_valid), 64'd0);
        tick();
        chk("rd_done_clear", 64'(rd_done), 64'd0);
        chk("rd_ready_back", 64'(rd_ready), 64'd1);
    endtask

    initial begin
        vecs[0] = '{4,   29'h100,        2, 1'b0, -1, 8'd3,   1'b0};
        vecs[1] = '{1,   29'h2000,       0, 1'b0, -1, 8'd0,   1'b0};
        vecs[2] = '{8,   29'h1F00,       1, 1'b1, -1, 8'd7,   1'b0};
        vecs[3] = '{4,   29'h40,         0, 1'b0,  1, 8'd3,   CHK};
        vecs[4] = '{2,   29'h80,         3, 1'b0, -1, 8'd1,   1'b0};
        vecs[5] = '{255, 29'h1FFF_F800,  0, 1'b0, -1, 8'd254, 1'b0};

        ARESETN       = 1'b0;
        rd_start      = 1'b0;
        rd_burst_len  = '0;
        rd_start_addr = '0;
        rd_fifo_full  = 1'b0;
        m_axi_arready = 1'b0;
        m_axi_rid     = 4'hF;
        m_axi_rdata   = '0;
        m_axi_rresp   = 2'b00;
        m_axi_rlast   = 1'b0;
        m_axi_rvalid  = 1'b0;
        tick();
        tick();
        chk("rst_rd_ready", 64'(rd_ready), 64'd1);
        chk("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
        chk("rst_rready", 64'(m_axi_rready), 64'd0);
        chk("rst_wr_valid", 64'(rd_fifo_wr_valid), 64'd0);
        chk("rst_rd_done", 64'(rd_done), 64'd0);
        chk("rst_rd_err", 64'(rd_err), 64'd0);
        chk("rst_araddr", 64'(m_axi_araddr), 64'd0);
        chk("rst_arlen", 64'(m_axi_arlen), 64'd0);
        ARESETN = 1'b1;
        tick();

        for (int k = 0; k < 6; k++) begin
            run_burst(vecs[k]);
            tick();
        end

        // Zero-length request must be ignored.
        rd_start      = 1'b1;
        rd_burst_len  = '0;
        rd_start_addr = 29'h555;
        tick();
        rd_start = 1'b0;
        chk("len0_rd_ready", 64'(rd_ready), 64'd1);
        chk("len0_arvalid", 64'(m_axi_arvalid), 64'd0);
        tick();
        chk("len0_arvalid2", 64'(m_axi_arvalid), 64'd0);
        chk("len0_rd_ready2", 64'(rd_ready), 64'd1);

        // Reset during the data phase, after two beats.
        rd_start      = 1'b1;
        rd_burst_len  = 8'd4;
        rd_start_addr = 29'h300;
        tick();
        rd_start = 1'b0;
        tick();
        m_axi_arready = 1'b1;
        tick();
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b1;
        m_axi_rdata   = 64'h1111;
        tick();
        m_axi_rdata = 64'h2222;
        tick();
        #2;
        chk("pre_rst_rready", 64'(m_axi_rready), 64'd1);
        ARESETN = 1'b0;
        #1;
        chk("midrst_arvalid", 64'(m_axi_arvalid), 64'd0);
        chk("midrst_rready", 64'(m_axi_rready), 64'd0);
        chk("midrst_rd_ready", 64'(rd_ready), 64'd1);
        chk("midrst_wr_valid", 64'(rd_fifo_wr_valid), 64'd0);
        chk("midrst_araddr", 64'(m_axi_araddr), 64'd0);
        m_axi_rvalid = 1'b0;
        tick();
        ARESETN = 1'b1;
        tick();
        run_burst(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, checks %0d", checks);
        $fatal(1);
    end

endmodule
